cache_req_arbiter: RTL and testbench
====================================

Name: cache_req_arbiter

Overview:
- Two-requester front end for the two-level direct-mapped cache system (L1 + L2 wrapper with a registered read_data/l1_hit/l2_hit interface).
- Arbitrates round-robin between requester 0 (instruction fetch) and requester 1 (data load).
- Sequences one lookup at a time and models main-memory latency on a double miss.
- Returns a one-cycle response pulse to the granted requester and keeps saturating hit/miss statistics.

Parameters:
- ADDR_WIDTH, 11, address width, matches the cache system.
- DATA_WIDTH, 11, data width, matches the cache system.
- MEM_LATENCY, 4, extra wait cycles on an L1+L2 miss before responding; legal range 1..15.
- CNT_WIDTH, 16, width of each statistics counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- req0_valid  in  1  requester 0 request
- req0_addr  in  ADDR_WIDTH  requester 0 address
- req0_ready  out  1  requester 0 accepted this cycle
- rsp0_valid  out  1  requester 0 response pulse
- rsp0_data  out  DATA_WIDTH  requester 0 response data
- req1_valid, req1_addr, req1_ready, rsp1_valid, rsp1_data: same as requester 0, for requester 1
- cache_read  out  1  read strobe to the cache system
- cache_addr  out  ADDR_WIDTH  address to the cache system
- cache_read_data  in  DATA_WIDTH  cache system read_data
- cache_l1_hit  in  1  cache system l1_hit
- cache_l2_hit  in  1  cache system l2_hit
- busy  out  1  high whenever state is not IDLE
- l1_hit_cnt, l2_hit_cnt, miss_cnt  out  CNT_WIDTH each  statistics

Behaviour:
- Reset values:
  - All outputs 0; state IDLE.
  - Round-robin pointer set so that requester 0 wins the first tie.
  - Counters 0; latched address 0.
  - Reset mid-operation aborts the transaction; no response is ever issued for it.
- States: IDLE, ISSUE, CHECK, MEM, RESP.
- IDLE:
  - If any reqN_valid is high, grant one requester.
  - On a tie, grant the requester not granted last; a single valid requester always wins.
  - reqN_ready is high combinationally for the granted requester only in this cycle.
  - Latch addr and grant id, then go to ISSUE.
  - reqN_ready is 0 in every other state.
- ISSUE:
  - cache_read = 1 and cache_addr = latched addr for exactly one cycle.
  - The cache system registers its result at this edge. Go to CHECK.
- CHECK: sample the cache outputs.
  - cache_l1_hit = 1: latch data, increment l1_hit_cnt, go to RESP.
  - Else cache_l2_hit = 1: latch data, increment l2_hit_cnt, go to RESP.
  - Else: latch data (memory fill value), increment miss_cnt, load the wait counter with MEM_LATENCY-1, go to MEM.
  - If both hit flags are high, treat it as an L1 hit.
- MEM: decrement the counter each cycle; when it reads 0, go to RESP. Total MEM residency is exactly MEM_LATENCY cycles.
- RESP:
  - rspN_valid = 1 for exactly one cycle on the granted id, with rspN_data = latched data.
  - The other requester's rsp stays 0.
  - Update the round-robin pointer to this grant, then go to IDLE.
- Outputs: cache_addr holds the latched addr outside ISSUE. rspN_data holds its last value when rspN_valid is 0.
- Latency from the accept cycle to the response pulse:
  - Hit (L1 or L2): 3 cycles.
  - Double miss: 3 + MEM_LATENCY cycles.
- Throughput: a new grant is possible the cycle after RESP.
- Requests: a requester holding valid without being accepted keeps its request pending; the arbiter never drops it. reqN_addr is sampled only in the accept cycle.
- Counters saturate at all-ones and never wrap.

Decomposition:
- Shared package cache_ctrl_pkg holds:
  - the state encoding constants (IDLE=0 … RESP=4, 3 bits);
  - the requester-id width;
  - a helper function for the saturating increment.
- One natural sub-module, rr_arbiter2: 2-way round-robin grant with a pointer update input. It is instantiated once.
- The counters and FSM stay in the top module.

Test Plan:
- Reset, then only req0_valid=1 with addr 0x012 on a cold cache -> double miss:
  - req0_ready pulses in the first cycle;
  - rsp0_valid pulses 3+4=7 cycles later with rsp0_data = 0x2BE (low 11 bits of the miss fill);
  - miss_cnt = 1.
- Bench cache model preloaded so addr 0x012 hits L1 with data 0x155, req1 only -> rsp1_valid 3 cycles after accept, rsp1_data = 0x155, l1_hit_cnt = 1, rsp0_valid never asserts.
- Both requesters valid continuously on L1-hit addresses -> grants alternate 0, 1, 0, 1; each response arrives 3 cycles after its own accept; neither side starves.
- L1 miss with L2 hit (data 0x0AA) -> rsp_data = 0x0AA, l2_hit_cnt increments, latency 3 cycles.
- rst asserted during MEM state -> all outputs 0 immediately (asynchronously), no response pulse afterwards, next request granted to requester 0 on a tie.
- Force l1_hit_cnt to 0xFFFE, then issue 3 L1 hits -> counter reads 0xFFFF and stays there.

Source files
------------

// File: rtl/cache_ctrl_pkg.sv
// Shared types and helpers for the cache request front end.
// State encoding, requester-id width and the saturating-counter helper.
package cache_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        CHECK = 3'd2,
        MEM   = 3'd3,
        RESP  = 3'd4
    } state_t;

    localparam int ID_WIDTH  = 1;
    localparam int WAIT_W    = 4;
    localparam int SAT_MAX_W = 32;

    // True when a w-bit counter (w <= SAT_MAX_W) holding v may still increment.
    function automatic logic sat_can_inc(input logic [SAT_MAX_W-1:0] v, input int unsigned w);
        logic [SAT_MAX_W-1:0] lim;
        lim = (SAT_MAX_W'(1) << w) - SAT_MAX_W'(1);
        return (v != lim);
    endfunction

endpackage

// File: rtl/cache_req_arbiter_rr.sv
// Two-way round-robin grant; the pointer remembers the last served requester.
// A tie goes to the requester that was not served last.
module rr_arbiter2
    import cache_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          req,
    input  logic                en,
    input  logic                upd,
    input  logic [ID_WIDTH-1:0] upd_id,
    output logic [1:0]          gnt,
    output logic [ID_WIDTH-1:0] gnt_id
);

    logic [ID_WIDTH-1:0] last_id;

    // Reset value 1 makes requester 0 win the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_id <= '1;
        end else if (upd) begin
            last_id <= upd_id;
        end
    end

    always_comb begin
        gnt = '0;
        if (req[0] && req[1]) begin
            gnt_id = ~last_id;
        end else begin
            gnt_id = req[1];
        end
        if (en && (|req)) begin
            gnt[gnt_id] = 1'b1;
        end
    end

endmodule

// File: rtl/cache_req_arbiter.sv
// Two-requester front end for the L1/L2 cache: round-robin grant, one lookup
// at a time, modelled memory latency on a double miss, saturating statistics.
module cache_req_arbiter
    import cache_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH  = 11,
    parameter int DATA_WIDTH  = 11,
    parameter int MEM_LATENCY = 4,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    output logic                  req0_ready,
    output logic                  rsp0_valid,
    output logic [DATA_WIDTH-1:0] rsp0_data,
    input  logic                  req1_valid,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    output logic                  req1_ready,
    output logic                  rsp1_valid,
    output logic [DATA_WIDTH-1:0] rsp1_data,
    output logic                  cache_read,
    output logic [ADDR_WIDTH-1:0] cache_addr,
    input  logic [DATA_WIDTH-1:0] cache_read_data,
    input  logic                  cache_l1_hit,
    input  logic                  cache_l2_hit,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  l1_hit_cnt,
    output logic [CNT_WIDTH-1:0]  l2_hit_cnt,
    output logic [CNT_WIDTH-1:0]  miss_cnt
);

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ID_WIDTH-1:0]   id_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] rsp0_data_q, rsp1_data_q;
    logic [WAIT_W-1:0]     wait_q;
    logic [1:0]            gnt;
    logic [ID_WIDTH-1:0]   gnt_id;
    logic                  accept;

    rr_arbiter2 u_rr (
        .clk    (clk),
        .rst    (rst),
        .req    ({req1_valid, req0_valid}),
        .en     ((state == IDLE) && !rst),
        .upd    (state == RESP),
        .upd_id (id_q),
        .gnt    (gnt),
        .gnt_id (gnt_id)
    );

    assign accept     = |gnt;
    assign req0_ready = gnt[0];
    assign req1_ready = gnt[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        busy       = (state != IDLE);
        cache_read = (state == ISSUE);
        cache_addr = addr_q;
        rsp0_valid = (state == RESP) && (id_q == '0);
        rsp1_valid = (state == RESP) && (id_q != '0);
        rsp0_data  = rsp0_valid ? data_q : rsp0_data_q;
        rsp1_data  = rsp1_valid ? data_q : rsp1_data_q;
        case (state)
            IDLE:    if (accept) state_nxt = ISSUE;
            ISSUE:   state_nxt = CHECK;
            CHECK:   state_nxt = (cache_l1_hit || cache_l2_hit) ? RESP : MEM;
            MEM:     if (wait_q == '0) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q      <= '0;
            id_q        <= '0;
            data_q      <= '0;
            wait_q      <= '0;
            rsp0_data_q <= '0;
            rsp1_data_q <= '0;
            l1_hit_cnt  <= '0;
            l2_hit_cnt  <= '0;
            miss_cnt    <= '0;
        end else begin
            if (accept) begin
                addr_q <= (gnt_id != '0) ? req1_addr : req0_addr;
                id_q   <= gnt_id;
            end
            // Both flags high counts as an L1 hit; on a miss the data bus carries the fill.
            if (state == CHECK) begin
                data_q <= cache_read_data;
                if (cache_l1_hit) begin
                    if (sat_can_inc(SAT_MAX_W'(l1_hit_cnt), CNT_WIDTH))
                        l1_hit_cnt <= l1_hit_cnt + CNT_WIDTH'(1);
                end else if (cache_l2_hit) begin
                    if (sat_can_inc(SAT_MAX_W'(l2_hit_cnt), CNT_WIDTH))
                        l2_hit_cnt <= l2_hit_cnt + CNT_WIDTH'(1);
                end else begin
                    if (sat_can_inc(SAT_MAX_W'(miss_cnt), CNT_WIDTH))
                        miss_cnt <= miss_cnt + CNT_WIDTH'(1);
                    wait_q <= WAIT_W'(MEM_LATENCY - 1);
                end
            end
            if (state == MEM && wait_q != '0) begin
                wait_q <= wait_q - WAIT_W'(1);
            end
            if (state == RESP) begin
                if (id_q == '0) rsp0_data_q <= data_q;
                else            rsp1_data_q <= data_q;
            end
        end
    end

endmodule

// File: tb/tb_cache_req_arbiter.sv
// Bench for cache_req_arbiter: a registered cache model plus a transaction-level
// reference that predicts grants, response timing, data and statistics each cycle.
module tb_cache_req_arbiter;

    localparam int AW  = 11;
    localparam int DW  = 11;
    localparam int LAT = 4;
    localparam int CW  = 16;

    logic          clk;
    logic          rst;
    logic          req0_valid, req1_valid;
    logic [AW-1:0] req0_addr, req1_addr;
    logic          req0_ready, req1_ready, rsp0_valid, rsp1_valid;
    logic [DW-1:0] rsp0_data, rsp1_data;
    logic          cache_read;
    logic [AW-1:0] cache_addr;
    logic [DW-1:0] cache_read_data = '0;
    logic          cache_l1_hit = 1'b0;
    logic          cache_l2_hit = 1'b0;
    logic          busy;
    logic [CW-1:0] l1_hit_cnt, l2_hit_cnt, miss_cnt;

    cache_req_arbiter #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .MEM_LATENCY (LAT),
        .CNT_WIDTH   (CW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .req0_valid      (req0_valid),
        .req0_addr       (req0_addr),
        .req0_ready      (req0_ready),
        .rsp0_valid      (rsp0_valid),
        .rsp0_data       (rsp0_data),
        .req1_valid      (req1_valid),
        .req1_addr       (req1_addr),
        .req1_ready      (req1_ready),
        .rsp1_valid      (rsp1_valid),
        .rsp1_data       (rsp1_data),
        .cache_read      (cache_read),
        .cache_addr      (cache_addr),
        .cache_read_data (cache_read_data),
        .cache_l1_hit    (cache_l1_hit),
        .cache_l2_hit    (cache_l2_hit),
        .busy            (busy),
        .l1_hit_cnt      (l1_hit_cnt),
        .l2_hit_cnt      (l2_hit_cnt),
        .miss_cnt        (miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cache system stand-in: result registered on the read strobe.
    bit            l1_has [2048];
    bit            l2_has [2048];
    logic [DW-1:0] l1_dat [2048];
    logic [DW-1:0] l2_dat [2048];

    function automatic logic [DW-1:0] fill(input logic [AW-1:0] a);
        return a ^ 11'h2AC;
    endfunction

    always @(posedge clk) begin
        if (cache_read) begin
            cache_l1_hit    <= l1_has[cache_addr];
            cache_l2_hit    <= l2_has[cache_addr];
            cache_read_data <= l1_has[cache_addr] ? l1_dat[cache_addr] :
                               l2_has[cache_addr] ? l2_dat[cache_addr] : fill(cache_addr);
        end
    end

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model state: one outstanding transaction described by its timeline.
    int            cyc;
    bit            txn;
    int            acc_cyc, rsp_cyc, tkind;
    bit            tid, last_g;
    logic [AW-1:0] cur_addr;
    logic [DW-1:0] tdata, last_d0, last_d1;
    int            e_l1, e_l2, e_miss;
    bit            acc0, acc1;
    bit            rec_grants;
    int            gseq[$];

    function automatic int sat(input int v);
        return (v >= 65535) ? 65535 : v + 1;
    endfunction

    task automatic model_reset();
        cyc = 0; txn = 0; acc_cyc = 0; rsp_cyc = 0; tkind = 0;
        tid = 0; last_g = 1; cur_addr = '0; tdata = '0;
        last_d0 = '0; last_d1 = '0; e_l1 = 0; e_l2 = 0; e_miss = 0;
    endtask

    task automatic check_cycle();
        bit idle, g, in_rsp;
        logic [AW-1:0] a;
        idle = !txn || (cyc > rsp_cyc);
        acc0 = 0; acc1 = 0;
        if (idle && (req0_valid || req1_valid)) begin
            g    = (req0_valid && req1_valid) ? !last_g : req1_valid;
            acc0 = !g;
            acc1 = g;
        end
        in_rsp = txn && (cyc == rsp_cyc);
        chk("req0_ready", req0_ready, acc0);
        chk("req1_ready", req1_ready, acc1);
        chk("busy", busy, txn && cyc > acc_cyc && cyc <= rsp_cyc);
        chk("cache_read", cache_read, txn && cyc == acc_cyc + 1);
        chk("cache_addr", cache_addr, cur_addr);
        chk("rsp0_valid", rsp0_valid, in_rsp && !tid);
        chk("rsp1_valid", rsp1_valid, in_rsp && tid);
        chk("rsp0_data", rsp0_data, (in_rsp && !tid) ? tdata : last_d0);
        chk("rsp1_data", rsp1_data, (in_rsp && tid) ? tdata : last_d1);
        chk("l1_hit_cnt", l1_hit_cnt, e_l1);
        chk("l2_hit_cnt", l2_hit_cnt, e_l2);
        chk("miss_cnt", miss_cnt, e_miss);
        if (rec_grants && (req0_ready || req1_ready)) gseq.push_back(int'(req1_ready));
        if (txn && cyc == acc_cyc + 2) begin
            if (tkind == 0)      e_l1   = sat(e_l1);
            else if (tkind == 1) e_l2   = sat(e_l2);
            else                 e_miss = sat(e_miss);
        end
        if (in_rsp) begin
            if (tid) last_d1 = tdata;
            else     last_d0 = tdata;
        end
        if (acc0 || acc1) begin
            a        = acc1 ? req1_addr : req0_addr;
            txn      = 1;
            tid      = acc1;
            last_g   = acc1;
            acc_cyc  = cyc;
            cur_addr = a;
            if (l1_has[a])      begin tkind = 0; tdata = l1_dat[a]; end
            else if (l2_has[a]) begin tkind = 1; tdata = l2_dat[a]; end
            else                begin tkind = 2; tdata = fill(a);   end
            rsp_cyc = cyc + 3 + ((tkind == 2) ? LAT : 0);
        end
        cyc++;
    endtask

    task automatic step();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ready0"}, req0_ready, 0);
        chk({tag, "_ready1"}, req1_ready, 0);
        chk({tag, "_rsp0"},   rsp0_valid, 0);
        chk({tag, "_rsp1"},   rsp1_valid, 0);
        chk({tag, "_rdata0"}, rsp0_data,  0);
        chk({tag, "_rdata1"}, rsp1_data,  0);
        chk({tag, "_read"},   cache_read, 0);
        chk({tag, "_addr"},   cache_addr, 0);
        chk({tag, "_busy"},   busy,       0);
        chk({tag, "_l1"},     l1_hit_cnt, 0);
        chk({tag, "_l2"},     l2_hit_cnt, 0);
        chk({tag, "_miss"},   miss_cnt,   0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [AW-1:0] pool [16];

    initial begin
        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_addr = '0; req1_addr = '0;
        rec_grants = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Cold double miss on requester 0.
        req0_valid = 1'b1; req0_addr = 11'h012;
        step();
        req0_valid = 1'b0;
        repeat (10) step();
        chk("A_rsp0_data", rsp0_data, 11'h2BE);
        chk("A_miss_cnt", miss_cnt, 1);

        // L1 hit on requester 1.
        l1_has[11'h012] = 1; l1_dat[11'h012] = 11'h155;
        req1_valid = 1'b1; req1_addr = 11'h012;
        step();
        req1_valid = 1'b0;
        repeat (6) step();
        chk("B_rsp1_data", rsp1_data, 11'h155);
        chk("B_l1_cnt", l1_hit_cnt, 1);
        chk("B_rsp0_held", rsp0_data, 11'h2BE);

        // Both requesters continuously valid on L1 hits.
        l1_has[11'h020] = 1; l1_dat[11'h020] = 11'h3C1;
        l1_has[11'h021] = 1; l1_dat[11'h021] = 11'h07E;
        req0_valid = 1'b1; req0_addr = 11'h020;
        req1_valid = 1'b1; req1_addr = 11'h021;
        rec_grants = 1;
        repeat (16) step();
        rec_grants = 0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (6) step();
        chk("C_grant_count", gseq.size(), 4);
        for (int i = 0; i < gseq.size(); i++) chk("C_grant_order", gseq[i], i % 2);

        // L1 miss, L2 hit.
        l2_has[11'h033] = 1; l2_dat[11'h033] = 11'h0AA;
        req0_valid = 1'b1; req0_addr = 11'h033;
        step();
        req0_valid = 1'b0;
        repeat (6) step();
        chk("D_rsp0_data", rsp0_data, 11'h0AA);
        chk("D_l2_cnt", l2_hit_cnt, 1);

        // Random traffic over L1-only, L2-only, both-hit and miss addresses.
        for (int i = 0; i < 16; i++) begin
            pool[i] = AW'(11'h100 + i);
            l1_has[pool[i]] = (i % 4 == 0) || (i % 4 == 2);
            l2_has[pool[i]] = (i % 4 == 1) || (i % 4 == 2);
            l1_dat[pool[i]] = DW'($urandom);
            l2_dat[pool[i]] = DW'($urandom);
        end
        for (int i = 0; i < 400; i++) begin
            step();
            if (!req0_valid || acc0) begin
                req0_valid = ($urandom_range(0, 9) < 6);
                req0_addr  = pool[$urandom_range(0, 15)];
            end
            if (!req1_valid || acc1) begin
                req1_valid = ($urandom_range(0, 9) < 6);
                req1_addr  = pool[$urandom_range(0, 15)];
            end
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (12) step();

        // Reset while waiting on memory: abort, then requester 0 wins the tie.
        req0_valid = 1'b1; req0_addr = 11'h3F0;
        step();
        repeat (3) step();
        chk("E_in_mem_busy", busy, 1);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("E_async");
        @(posedge clk);
        #1;
        check_all_zero("E_held");
        rst = 1'b0;
        model_reset();
        req0_addr = 11'h020;
        req1_valid = 1'b1; req1_addr = 11'h021;
        #1;
        chk("E_tie_ready0", req0_ready, 1);
        chk("E_tie_ready1", req1_ready, 0);
        for (int i = 0; i < 14; i++) begin
            step();
            if (acc0) req0_valid = 1'b0;
            if (acc1) req1_valid = 1'b0;
        end
        chk("E_no_miss", miss_cnt, 0);
        chk("E_l1_after", l1_hit_cnt, 2);

        // Saturation of the L1 hit counter.
        force dut.l1_hit_cnt = 16'hFFFE;
        @(posedge clk);
        #1;
        release dut.l1_hit_cnt;
        e_l1 = 32'hFFFE;
        chk("F_forced", l1_hit_cnt, 16'hFFFE);
        for (int k = 0; k < 3; k++) begin
            req0_valid = 1'b1; req0_addr = 11'h020;
            step();
            req0_valid = 1'b0;
            repeat (4) step();
        end
        chk("F_saturated", l1_hit_cnt, 16'hFFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
